// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one 16-bit {rw, addr[6:0], data[7:0]} frame per
// command, MSB first, and returns the read byte captured during the data phase.
module spi_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI,
  input  logic       CIPO
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]    r_bit, w_bit_nxt;
  logic [FRAME_W-1:0]  r_frame, w_frame_nxt;
  logic [DATA_W-1:0]   r_rx, w_rx_nxt;
  logic                r_sclk, w_sclk_nxt;
  logic                r_ncs, w_ncs_nxt;
  logic                r_copi, w_copi_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;

  // State and every pin-facing output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_frame     <= '0;
      r_rx        <= '0;
      r_sclk      <= 1'b0;
      r_ncs       <= 1'b1;
      r_copi      <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_frame     <= w_frame_nxt;
      r_rx        <= w_rx_nxt;
      r_sclk      <= w_sclk_nxt;
      r_ncs       <= w_ncs_nxt;
      r_copi      <= w_copi_nxt;
      r_ready     <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_nxt       = r_bit;
    w_frame_nxt     = r_frame;
    w_rx_nxt        = r_rx;
    w_sclk_nxt      = r_sclk;
    w_ncs_nxt       = r_ncs;
    w_copi_nxt      = r_copi;
    w_ready_nxt     = r_ready;
    w_busy_nxt      = r_busy;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;

    case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        if (cmd_valid && r_ready) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_frame_nxt = {cmd_rw, cmd_addr, cmd_wdata};
          w_ncs_nxt   = 1'b0;
          w_copi_nxt  = cmd_rw;
          w_sclk_nxt  = 1'b0;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end

      S_SETUP: begin
        if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      // Each SCLK phase lasts CLK_DIV cycles; CIPO is taken as SCLK goes high and
      // COPI moves as it goes low, so COPI is stable across every rising edge.
      S_SHIFT: begin
        if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
          w_cnt_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
            if (r_bit[BIT_W-1]) begin
              w_rx_nxt = {r_rx[DATA_W-2:0], CIPO};
            end
          end else begin
            w_sclk_nxt = 1'b0;
            if (r_bit == BIT_W'(FRAME_W - 1)) begin
              w_state_nxt = S_HOLD;
            end else begin
              w_copi_nxt = r_frame[BIT_W'(FRAME_W - 2) - r_bit];
              w_bit_nxt  = r_bit + BIT_W'(1);
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
          w_state_nxt     = S_GAP;
          w_cnt_nxt       = '0;
          w_ncs_nxt       = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_frame[FRAME_W-1] ? '0 : r_rx;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (r_cnt == CNT_W'(CS_IDLE - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign SCLK      = r_sclk;
  assign nCS       = r_ncs;
  assign COPI      = r_copi;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: table of single frames plus hand-written
// sequences for back-to-back, command noise while busy, mid-frame reset and fast timing.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       sclk;
  logic       ncs;
  logic       copi;
  logic       cipo = 1'b0;

  logic       f_valid = 1'b0;
  logic       f_ready;
  logic       f_rw = 1'b0;
  logic [6:0] f_addr = '0;
  logic [7:0] f_wdata = '0;
  logic       f_rsp_valid;
  logic [7:0] f_rsp_rdata;
  logic       f_busy;
  logic       f_sclk;
  logic       f_ncs;
  logic       f_copi;
  logic       f_cipo = 1'b0;

  always #5 clk = ~clk;

  spi_controller dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .SCLK(sclk), .nCS(ncs), .COPI(copi), .CIPO(cipo)
  );

  spi_controller #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .cmd_valid(f_valid), .cmd_ready(f_ready),
    .cmd_rw(f_rw), .cmd_addr(f_addr), .cmd_wdata(f_wdata),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .busy(f_busy),
    .SCLK(f_sclk), .nCS(f_ncs), .COPI(f_copi), .CIPO(f_cipo)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          t0, ncs_fall, first_rise, last_fall, rises, rsp_t, rsp_cnt, ready_t, gap;
    logic [15:0] copi;
    logic [7:0]  rdata;
  } frame_t;

  frame_t     cur;
  frame_t     frames[$];
  bit         cur_active = 1'b0;
  int         n_acc = 0;
  int         n_rsp = 0;
  int         sclk_viol = 0;
  int         falls = 0;
  logic [7:0] cipo_byte = '0;
  logic       p_ready = 1'b0;
  logic       p_ncs = 1'b1;
  logic       p_sclk = 1'b0;

  // Pin monitor, 1 time unit after each edge; a value seen after edge n is the value at n+1.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      cur_active = 1'b0;
    end else begin
      if (cmd_valid && p_ready) begin
        cur = '{default: 0};
        cur.t0 = cyc;
        cur_active = 1'b1;
        falls = 0;
        n_acc++;
      end
      if (p_ncs && !ncs) begin
        cur.ncs_fall = cyc + 1;
        cipo = 1'b0;
      end
      if (!p_sclk && sclk) begin
        if (cur.rises == 0) cur.first_rise = cyc + 1;
        cur.rises++;
        cur.copi = {cur.copi[14:0], copi};
      end
      if (p_sclk && !sclk) begin
        cur.last_fall = cyc + 1;
        falls++;
        if (falls >= 8 && falls <= 15) cipo = cipo_byte[15 - falls];
      end
      if (rsp_valid) begin
        cur.rsp_t = cyc + 1;
        cur.rsp_cnt++;
        cur.rdata = rsp_rdata;
        n_rsp++;
      end
      if (ncs && busy) cur.gap++;
      if (!p_ready && cmd_ready && cur_active) begin
        cur.ready_t = cyc + 1;
        frames.push_back(cur);
        cur_active = 1'b0;
      end
    end
    if (sclk && ncs) sclk_viol++;
    if (f_sclk && f_ncs) sclk_viol++;
    p_ready = cmd_ready;
    p_ncs   = ncs;
    p_sclk  = sclk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cmd_ready && n < 300) begin
      tick();
      n++;
    end
    if (!cmd_ready) timeout_fail(name);
  endtask

  task automatic start_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wd);
    wait_ready("ready_before_cmd");
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    tick();
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (frames.size() < target && n < 400) begin
      tick();
      n++;
    end
    if (frames.size() < target) timeout_fail(name);
  endtask

  task automatic check_frame(input string tag, input frame_t f,
                             input logic [15:0] exp_copi, input logic [7:0] exp_rdata);
    check({tag, "_copi"},       32'(f.copi), 32'(exp_copi));
    check({tag, "_rdata"},      32'(f.rdata), 32'(exp_rdata));
    check({tag, "_rises"},      f.rises, 16);
    check({tag, "_ncs_fall"},   f.ncs_fall - f.t0, 1);
    check({tag, "_first_rise"}, f.first_rise - f.t0, 7);
    check({tag, "_last_fall"},  f.last_fall - f.t0, 131);
    check({tag, "_rsp_t"},      f.rsp_t - f.t0, 133);
    check({tag, "_rsp_cnt"},    f.rsp_cnt, 1);
    check({tag, "_ready_t"},    f.ready_t - f.t0, 137);
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  cipo;
    logic [15:0] exp_copi;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int          nf;
    int          a0;
    int          nr;
    int          n;
    int          t0;
    int          t;
    int          fr;
    int          f_rsp_t;
    int          f_ready_t;
    int          rise_t[16];
    logic [15:0] f_sh;
    logic [7:0]  f_rd;
    logic        fp_sclk;
    logic        fp_ready;

    vecs[0] = '{1'b1, 7'h00, 8'hA5, 8'h00, 16'h80A5, 8'h00};
    vecs[1] = '{1'b0, 7'h04, 8'h5A, 8'h3C, 16'h045A, 8'h3C};
    vecs[2] = '{1'b1, 7'h7F, 8'h00, 8'hFF, 16'hFF00, 8'h00};
    vecs[3] = '{1'b0, 7'h55, 8'hC3, 8'h81, 16'h55C3, 8'h81};

    // Reset values, then cmd_ready on the first edge after release.
    tick();
    tick();
    check("rst_ncs", 32'(ncs), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_copi", 32'(copi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    rst_n = 1'b1;
    check("rst_ready_before_edge", 32'(cmd_ready), 0);
    tick();
    check("ready_after_release", 32'(cmd_ready), 1);

    for (int i = 0; i < 4; i++) begin
      cipo_byte = vecs[i].cipo;
      nf = frames.size();
      start_cmd(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      cmd_valid = 1'b0;
      wait_frames(nf + 1, $sformatf("v%0d_frame", i));
      if (frames.size() > nf)
        check_frame($sformatf("v%0d", i), frames[nf], vecs[i].exp_copi, vecs[i].exp_rdata);
    end

    // Reset asserted while SCLK is high after the 6th rise of a write.
    nr = n_rsp;
    start_cmd(1'b1, 7'h20, 8'h77);
    cmd_valid = 1'b0;
    n = 0;
    while (cur.rises < 6 && n < 200) begin
      tick();
      n++;
    end
    if (cur.rises < 6) timeout_fail("midrst_rise6");
    check("midrst_sclk_high", 32'(sclk), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ncs", 32'(ncs), 1);
    check("midrst_sclk", 32'(sclk), 0);
    check("midrst_copi", 32'(copi), 0);
    check("midrst_ready", 32'(cmd_ready), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_rdata", 32'(rsp_rdata), 0);
    tick();
    tick();
    rst_n = 1'b1;
    nf = frames.size();
    cipo_byte = 8'h00;
    start_cmd(1'b1, 7'h21, 8'h3C);
    cmd_valid = 1'b0;
    wait_frames(nf + 1, "midrst_after_frame");
    if (frames.size() > nf) check_frame("midrst_after", frames[nf], 16'hA13C, 8'h00);
    check("midrst_rsp_count", n_rsp - nr, 1);

    // Back-to-back writes with cmd_valid held high.
    nf = frames.size();
    wait_ready("b2b_ready");
    a0 = n_acc;
    cmd_rw = 1'b1;
    cmd_addr = 7'h02;
    cmd_wdata = 8'h11;
    cmd_valid = 1'b1;
    n = 0;
    while (n_acc < a0 + 1 && n < 10) begin
      tick();
      n++;
    end
    cmd_addr = 7'h03;
    cmd_wdata = 8'h22;
    n = 0;
    while (n_acc < a0 + 2 && n < 300) begin
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    if (n_acc < a0 + 2) timeout_fail("b2b_second_accept");
    wait_frames(nf + 2, "b2b_frames");
    if (frames.size() >= nf + 2) begin
      check_frame("b2b_1", frames[nf], 16'h8211, 8'h00);
      check_frame("b2b_2", frames[nf + 1], 16'h8322, 8'h00);
      check("b2b_accept_spacing", frames[nf + 1].t0 - frames[nf].t0, 137);
      check("b2b_gap_ncs_high_busy", frames[nf].gap, 4);
    end

    // Command inputs thrash while busy; only the first command may be taken.
    nf = frames.size();
    a0 = n_acc;
    nr = n_rsp;
    start_cmd(1'b1, 7'h10, 8'h5A);
    n = 0;
    while (!cmd_ready && n < 300) begin
      cmd_valid = ~cmd_valid;
      cmd_rw    = 1'($urandom);
      cmd_addr  = 7'($urandom);
      cmd_wdata = 8'($urandom);
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    if (!cmd_ready) timeout_fail("noise_ready");
    tick();
    tick();
    wait_frames(nf + 1, "noise_frame");
    if (frames.size() > nf) check_frame("noise", frames[nf], 16'h905A, 8'h00);
    check("noise_accepts", n_acc - a0, 1);
    check("noise_rsp_count", n_rsp - nr, 1);

    // Minimum-timing instance: CLK_DIV=2, all CS timings 1.
    n = 0;
    while (!f_ready && n < 20) begin
      tick();
      n++;
    end
    if (!f_ready) timeout_fail("fast_ready");
    f_rw = 1'b1;
    f_addr = 7'h01;
    f_wdata = 8'hFF;
    f_valid = 1'b1;
    t0 = cyc + 1;
    tick();
    f_valid = 1'b0;
    check("fast_ncs_low", 32'(f_ncs), 0);
    check("fast_busy", 32'(f_busy), 1);
    fr = 0;
    f_sh = '0;
    f_rd = 8'hEE;
    f_rsp_t = -1;
    f_ready_t = -1;
    fp_sclk = 1'b0;
    fp_ready = 1'b0;
    for (int i = 0; i < 80; i++) begin
      t = cyc + 1 - t0;
      if (f_sclk && !fp_sclk) begin
        if (fr < 16) rise_t[fr] = t;
        fr++;
        f_sh = {f_sh[14:0], f_copi};
      end
      if (f_rsp_valid && f_rsp_t < 0) begin
        f_rsp_t = t;
        f_rd = f_rsp_rdata;
      end
      if (f_ready && !fp_ready && f_ready_t < 0) f_ready_t = t;
      fp_sclk = f_sclk;
      fp_ready = f_ready;
      tick();
    end
    check("fast_rises", fr, 16);
    check("fast_copi", 32'(f_sh), 32'h81FF);
    if (fr >= 16) begin
      check("fast_first_rise", rise_t[0], 4);
      check("fast_period", rise_t[1] - rise_t[0], 4);
      check("fast_last_rise", rise_t[15] - rise_t[0], 60);
    end
    check("fast_rsp_t", f_rsp_t, 67);
    check("fast_rdata", 32'(f_rd), 0);
    check("fast_ready_t", f_ready_t, 68);

    check("sclk_toggle_while_ncs_high", sclk_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
